deser_lane_arbiter: RTL and testbench
=====================================

Name: deser_lane_arbiter

Overview:
- Round-robin scheduler that shares one serial-to-parallel deserializer (DATA_BUS_WIDTH-bit word) between NUM_LANES serial requesters.
- Grants one lane at a time for exactly one full word and forwards that lane's bit stream to the deserializer, registered.
- On a lane abort, issues a flush pulse to the deserializer so partial words are discarded.
- Sits between the lane front-ends and the deserializer's serial input.

Parameters:
- NUM_LANES, 4, number of serial requesters (2..16).
- DATA_BUS_WIDTH, 16, bits per deserialized word; must match the deserializer.
- TIMEOUT_CYCLES, 64, idle-bit watchdog limit while granted (used only with the optional feature).

Ports:
- clk_i  in  1  single clock.
- arst_n_i  in  1  asynchronous active-low reset.
- req_i  in  NUM_LANES  per-lane request, held high for the whole word.
- data_i  in  NUM_LANES  per-lane serial bit.
- data_val_i  in  NUM_LANES  per-lane bit valid.
- gnt_o  out  NUM_LANES  one-hot grant, or zero.
- deser_data_o  out  1  forwarded bit to the deserializer.
- deser_data_val_o  out  1  forwarded bit valid.
- deser_srst_o  out  1  one-cycle flush to the deserializer's synchronous reset.
- src_id_o  out  $clog2(NUM_LANES)  lane of the word in flight; stable from grant through word_done_o.
- word_done_o  out  1  pulses with the last forwarded bit of a word.

Behaviour:
- Reset (async assert, sync deassert by the user): state=IDLE. Round-robin pointer=0. Bit count=0. All outputs 0.
- States: IDLE, GRANT, FLUSH.
- IDLE:
  - If any req_i is high, select the first requesting lane at or after the pointer, with wrap-around.
  - Next cycle: gnt_o[k]=1, src_id_o=k, state=GRANT, count=0.
  - If no request, stay in IDLE with gnt_o=0.
- GRANT, bit acceptance:
  - A bit is accepted when gnt_o[k] && req_i[k] && data_val_i[k].
  - Accepted bit is registered to deser_data_o/deser_data_val_o one cycle later (1-cycle latency).
  - Count increments on each accepted bit.
  - data_val_i on non-granted lanes is ignored; there is no backpressure.
- GRANT, word completion:
  - Accepting bit DATA_BUS_WIDTH-1 (count wraps to 0) at cycle t gives, at t+1: deser_data_val_o=1, word_done_o=1, gnt_o=0, state=IDLE, pointer=k+1 mod NUM_LANES.
  - Earliest next grant is t+2. There is always at least one idle cycle between grants.
- GRANT, abort:
  - req_i[k] low while count>0: any same-cycle data_val is not accepted. Next cycle state=FLUSH, gnt_o=0.
  - req_i[k] low with count==0: go straight to IDLE with no flush; pointer advances.
- FLUSH:
  - deser_srst_o=1 for exactly one cycle, word_done_o=0.
  - Then IDLE; pointer=k+1.
- Fairness: a lane that just completed or aborted has lowest priority in the next arbitration.
- Simultaneous events:
  - Multiple req in IDLE are resolved by the pointer.
  - A new req arriving in the cycle word_done_o pulses is evaluated in that IDLE cycle.
- Outputs are registered; no combinational input-to-output path.

Optional Feature:
- Macro DESER_LANE_ARB_TIMEOUT_EN.
- When defined: a watchdog counter clears on every accepted bit and on grant, and increments each GRANT cycle with no accepted bit. When it reaches TIMEOUT_CYCLES, the arbiter takes the abort path: FLUSH if count>0, else IDLE. Pointer advances either way.
- When undefined: no watchdog logic. A granted lane holding req without data stalls the arbiter indefinitely, and TIMEOUT_CYCLES is unused.

Decomposition:
- Package deser_lane_arb_pkg:
  - state enum (IDLE, GRANT, FLUSH).
  - localparam functions for LANE_ID_W=$clog2(NUM_LANES) and CNT_W=$clog2(DATA_BUS_WIDTH).
- Sub-module rr_pick: combinational round-robin selector. Inputs: request vector and pointer. Outputs: one-hot select and lane index. Kept separate so it can be reused by other schedulers.

Test Plan:
- Single lane 2 requests, sends 16 valid bits back-to-back -> gnt_o=4'b0100 one cycle after req; 16 deser_data_val_o pulses, each 1 cycle after its input bit; word_done_o on the 16th with src_id_o=2; gnt_o=0 the following cycle.
- req_i=4'b1111 held, each lane sends 16 bits -> grant order 0,1,2,3,0; exactly 16 forwarded bits per grant; 1 idle cycle between grants.
- Lane 1 granted, sends 5 bits, drops req -> no word_done_o; deser_srst_o=1 for exactly 1 cycle; next grant goes to lane 2 if requesting.
- Lane 0 granted, lane 3 toggles data_val_i with random data -> deser_data_o carries only lane 0 bits; forwarded bit count is exactly 16.
- arst_n_i pulsed low mid-word (count=9) -> all outputs 0 immediately; after release, arbitration restarts at lane 0 with count=0.
- With DESER_LANE_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8: lane 0 sends 3 bits then holds req with no valid for 8 cycles -> deser_srst_o pulse, grant moves to the next requesting lane. Without the macro, the grant is held.

Source files
------------

// File: rtl/deser_lane_arb_pkg.sv
// Shared types and width helpers for the deserializer lane arbiter.
package deser_lane_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      FLUSH
   } arb_state_t;

   function automatic int lane_id_w(input int num_lanes);
      return (num_lanes > 1) ? $clog2(num_lanes) : 1;
   endfunction

   function automatic int cnt_w(input int data_bus_width);
      return (data_bus_width > 1) ? $clog2(data_bus_width) : 1;
   endfunction

endpackage

// File: rtl/deser_lane_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after the
// pointer, wrapping around. Standalone so other schedulers can reuse it.
module rr_pick
   import deser_lane_arb_pkg::*;
#(
   parameter int NUM_LANES = 4,
   localparam int ID_W = lane_id_w(NUM_LANES)
) (
   input  logic [NUM_LANES-1:0] req,
   input  logic [ID_W-1:0]      ptr,
   output logic [NUM_LANES-1:0] sel,
   output logic [ID_W-1:0]      idx,
   output logic                 valid
);

   logic [ID_W-1:0] cand;

   always_comb begin
      sel   = '0;
      idx   = '0;
      valid = 1'b0;
      cand  = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         cand = ID_W'((int'(ptr) + i) % NUM_LANES);
         if (!valid && req[cand]) begin
            valid     = 1'b1;
            idx       = cand;
            sel[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/deser_lane_arbiter.sv
// Round-robin arbiter sharing one deserializer between serial lanes.
// Optional idle-bit watchdog enabled by defining DESER_LANE_ARB_TIMEOUT_EN.
module deser_lane_arbiter
   import deser_lane_arb_pkg::*;
#(
   parameter int NUM_LANES      = 4,
   parameter int DATA_BUS_WIDTH = 16,
   parameter int TIMEOUT_CYCLES = 64,
   localparam int LANE_ID_W = lane_id_w(NUM_LANES),
   localparam int CNT_W     = cnt_w(DATA_BUS_WIDTH)
) (
   input  logic                 clk_i,
   input  logic                 arst_n_i,
   input  logic [NUM_LANES-1:0] req_i,
   input  logic [NUM_LANES-1:0] data_i,
   input  logic [NUM_LANES-1:0] data_val_i,
   output logic [NUM_LANES-1:0] gnt_o,
   output logic                 deser_data_o,
   output logic                 deser_data_val_o,
   output logic                 deser_srst_o,
   output logic [LANE_ID_W-1:0] src_id_o,
   output logic                 word_done_o
);

   arb_state_t           state;
   logic [LANE_ID_W-1:0] ptr;
   logic [CNT_W-1:0]     cnt;
   logic [NUM_LANES-1:0] pick_sel;
   logic [LANE_ID_W-1:0] pick_idx;
   logic                 pick_valid;
   logic                 lane_req, lane_val, lane_bit;
   logic                 accept, last_bit, timeout, abort;
   logic [LANE_ID_W-1:0] next_ptr;

   // Unsupported parameter sets show up as this marker scope in the hierarchy.
   if (NUM_LANES < 2 || NUM_LANES > 16 || DATA_BUS_WIDTH < 2 || TIMEOUT_CYCLES < 1) begin : g_unsupported_config
   end

   rr_pick #(.NUM_LANES(NUM_LANES)) u_rr_pick (
      .req   (req_i),
      .ptr   (ptr),
      .sel   (pick_sel),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   assign lane_req = req_i[src_id_o];
   assign lane_val = data_val_i[src_id_o];
   assign lane_bit = data_i[src_id_o];
   assign accept   = (state == GRANT) && lane_req && lane_val;
   assign last_bit = (cnt == CNT_W'(DATA_BUS_WIDTH - 1));
   assign next_ptr = (src_id_o == LANE_ID_W'(NUM_LANES - 1)) ? '0 : src_id_o + 1'b1;
   assign abort    = (state == GRANT) && (!lane_req || timeout);

`ifdef DESER_LANE_ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wdog;

   // Fires on the idle GRANT cycle that would bring the counter to the limit.
   assign timeout = (state == GRANT) && !accept && (wdog == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         wdog <= '0;
      end else if (state != GRANT || accept) begin
         wdog <= '0;
      end else begin
         wdog <= wdog + 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state            <= IDLE;
         ptr              <= '0;
         cnt              <= '0;
         gnt_o            <= '0;
         src_id_o         <= '0;
         deser_data_o     <= 1'b0;
         deser_data_val_o <= 1'b0;
         deser_srst_o     <= 1'b0;
         word_done_o      <= 1'b0;
      end else begin
         deser_data_val_o <= 1'b0;
         deser_srst_o     <= 1'b0;
         word_done_o      <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  gnt_o    <= pick_sel;
                  src_id_o <= pick_idx;
                  cnt      <= '0;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               if (abort) begin
                  gnt_o <= '0;
                  // Only a partially assembled word needs the deserializer flushed.
                  if (cnt != '0) begin
                     state        <= FLUSH;
                     deser_srst_o <= 1'b1;
                  end else begin
                     state <= IDLE;
                     ptr   <= next_ptr;
                  end
               end else if (accept) begin
                  deser_data_o     <= lane_bit;
                  deser_data_val_o <= 1'b1;
                  if (last_bit) begin
                     cnt         <= '0;
                     word_done_o <= 1'b1;
                     gnt_o       <= '0;
                     state       <= IDLE;
                     ptr         <= next_ptr;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            FLUSH: begin
               state <= IDLE;
               ptr   <= next_ptr;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_deser_lane_arbiter.sv
// Self-checking bench for deser_lane_arbiter: table of grant/word records plus
// hand-written reset and watchdog sequences, with a forwarded-bit scoreboard.
module tb_deser_lane_arbiter;

   localparam int N  = 4;
   localparam int W  = 16;
   localparam int TO = 8;

   logic         clk_i = 1'b0;
   logic         arst_n_i = 1'b1;
   logic [N-1:0] req_i = '0;
   logic [N-1:0] data_i = '0;
   logic [N-1:0] data_val_i = '0;
   logic [N-1:0] gnt_o;
   logic         deser_data_o;
   logic         deser_data_val_o;
   logic         deser_srst_o;
   logic [1:0]   src_id_o;
   logic         word_done_o;

   typedef struct {
      int   lane;
      logic bit_v;
      int   due;
      bit   last;
   } exp_t;

   typedef struct {
      logic [N-1:0] req;
      int           lane;
      int           wait_cyc;
      int           nbits;
      int           flushes;
      bit           gappy;
   } vec_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   srst_cnt = 0;
   int   s0 = 0;

   always #5 clk_i = ~clk_i;

   deser_lane_arbiter #(
      .NUM_LANES      (N),
      .DATA_BUS_WIDTH (W),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk_i            (clk_i),
      .arst_n_i         (arst_n_i),
      .req_i            (req_i),
      .data_i           (data_i),
      .data_val_i       (data_val_i),
      .gnt_o            (gnt_o),
      .deser_data_o     (deser_data_o),
      .deser_data_val_o (deser_data_val_o),
      .deser_srst_o     (deser_srst_o),
      .src_id_o         (src_id_o),
      .word_done_o      (word_done_o)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_i);
   endtask

   always @(posedge clk_i) cyc <= cyc + 1;

   // Forwarded bits must appear exactly one cycle after the bench drove them.
   always @(negedge clk_i) begin
      if (deser_srst_o) srst_cnt <= srst_cnt + 1;
      if (sb.size() > 0 && sb[0].due < cyc) begin
         checkOutput("fwd_missing_due", cyc, sb[0].due);
         void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
         checkOutput("fwd_val", deser_data_val_o, 1);
         checkOutput("fwd_data", deser_data_o, sb[0].bit_v);
         checkOutput("word_done", word_done_o, sb[0].last);
         if (sb[0].last) checkOutput("done_src_id", src_id_o, sb[0].lane);
         void'(sb.pop_front());
      end else begin
         if (deser_data_val_o) checkOutput("fwd_unexpected_val", deser_data_val_o, 0);
         if (word_done_o) checkOutput("done_unexpected", word_done_o, 0);
      end
   end

   task automatic waitGrant(input int lane, input int exp_wait);
      int n;
      n = 0;
      do begin
         tick();
         n++;
         data_val_i = '0;
      end while (gnt_o == '0 && n < 30);
      checkOutput("grant_onehot", gnt_o, 32'(1) << lane);
      checkOutput("grant_src_id", src_id_o, lane);
      checkOutput("grant_latency", n, exp_wait);
   endtask

   task automatic applyStimulus(input int lane, input int nbits, input bit gappy);
      for (int i = 0; i < nbits; i++) begin
         if (gappy && $urandom_range(1) == 1) begin
            data_val_i       = 4'($urandom);
            data_val_i[lane] = 1'b0;
            data_i           = 4'($urandom);
            tick();
         end
         data_val_i       = 4'($urandom);
         data_i           = 4'($urandom);
         data_val_i[lane] = 1'b1;
         sb.push_back('{lane, data_i[lane], cyc + 1, (i == W - 1)});
         tick();
      end
      data_val_i = '0;
      if (nbits == W) begin
         checkOutput("done_pulse", word_done_o, 1);
         checkOutput("done_src", src_id_o, lane);
         checkOutput("gnt_after_done", gnt_o, 0);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      vec_t vecs[14];
      vecs[0]  = '{4'b0100, 2, 1, 16, 0, 1'b0};
      vecs[1]  = '{4'b1111, 3, 1, 16, 0, 1'b0};
      vecs[2]  = '{4'b1111, 0, 1, 16, 0, 1'b0};
      vecs[3]  = '{4'b1111, 1, 1, 16, 0, 1'b0};
      vecs[4]  = '{4'b1111, 2, 1, 16, 0, 1'b0};
      vecs[5]  = '{4'b1111, 3, 1, 16, 0, 1'b0};
      vecs[6]  = '{4'b1111, 0, 1, 16, 0, 1'b0};
      vecs[7]  = '{4'b0110, 1, 1,  5, 0, 1'b0};
      vecs[8]  = '{4'b0100, 2, 3, 16, 1, 1'b0};
      vecs[9]  = '{4'b0001, 0, 1,  0, 0, 1'b0};
      vecs[10] = '{4'b1000, 3, 2, 16, 0, 1'b0};
      vecs[11] = '{4'b0011, 0, 1, 16, 0, 1'b1};
      vecs[12] = '{4'b0011, 1, 1, 16, 0, 1'b1};
      vecs[13] = '{4'b0011, 0, 1, 16, 0, 1'b1};

      #1 arst_n_i = 1'b0;
      repeat (3) tick();
      checkOutput("rst_gnt", gnt_o, 0);
      checkOutput("rst_src_id", src_id_o, 0);
      checkOutput("rst_val", deser_data_val_o, 0);
      checkOutput("rst_srst", deser_srst_o, 0);
      checkOutput("rst_done", word_done_o, 0);
      arst_n_i = 1'b1;

      for (int r = 0; r < 14; r++) begin
         req_i      = vecs[r].req;
         data_val_i = '1;
         data_i     = 4'($urandom);
         s0         = srst_cnt;
         waitGrant(vecs[r].lane, vecs[r].wait_cyc);
         checkOutput("flush_pulses", srst_cnt - s0, vecs[r].flushes);
         applyStimulus(vecs[r].lane, vecs[r].nbits, vecs[r].gappy);
      end

      // Reset in the middle of a word (nine bits in); pointer must restart at 0.
      req_i = 4'b0001;
      waitGrant(0, 1);
      applyStimulus(0, 9, 1'b0);
      tick();
      #2 arst_n_i = 1'b0;
      #1;
      checkOutput("midrst_gnt", gnt_o, 0);
      checkOutput("midrst_src_id", src_id_o, 0);
      checkOutput("midrst_val", deser_data_val_o, 0);
      checkOutput("midrst_data", deser_data_o, 0);
      checkOutput("midrst_srst", deser_srst_o, 0);
      checkOutput("midrst_done", word_done_o, 0);
      tick();
      req_i    = 4'b1001;
      arst_n_i = 1'b1;
      waitGrant(0, 1);
      applyStimulus(0, W, 1'b0);

      // Granted lane stalls after three bits while lane 3 waits.
      req_i = 4'b0001;
      waitGrant(0, 1);
      applyStimulus(0, 3, 1'b0);
      req_i = 4'b1001;
      s0    = srst_cnt;
`ifdef DESER_LANE_ARB_TIMEOUT_EN
      for (int t = 1; t <= TO; t++) begin
         tick();
         if (t < TO) checkOutput("wdog_early_srst", deser_srst_o, 0);
      end
      checkOutput("wdog_srst", deser_srst_o, 1);
      checkOutput("wdog_gnt_drop", gnt_o, 0);
      waitGrant(3, 2);
      checkOutput("wdog_flush_pulses", srst_cnt - s0, 1);
`else
      repeat (20) tick();
      checkOutput("hold_no_flush", srst_cnt - s0, 0);
      checkOutput("hold_gnt", gnt_o, 4'b0001);
      s0    = srst_cnt;
      req_i = 4'b1000;
      waitGrant(3, 3);
      checkOutput("hold_abort_flush", srst_cnt - s0, 1);
`endif
      applyStimulus(3, W, 1'b0);
      req_i = '0;
      repeat (4) tick();
      checkOutput("final_idle_gnt", gnt_o, 0);
      checkOutput("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
